// File: rtl/matrix_stream_loader.sv
// matrix_stream_loader
//   Collects a 32-element stream into two 4x4 matrices, A then B, and holds
//   them for a downstream multiplier until it takes the pair.
//   Optional build macro: MATLOAD_TRANSPOSE_B_EN (B written column-major).
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   upstream element valid
//   in_ready   loader can accept an element (low while holding a pair)
//   in_data    element value, ELEM_W bits
//   in_sof     start-of-frame; restarts the frame at A[0][0] on a transfer
//   a_flat     A[i][k] at [(i*4+k)*ELEM_W +: ELEM_W]
//   b_flat     B[k][j] at [(k*4+j)*ELEM_W +: ELEM_W]
//   mat_valid  A and B complete and stable
//   mat_ready  downstream consumes the pair
//   elem_cnt   elements accepted in the current frame
module matrix_stream_loader #(
  parameter int ELEM_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ELEM_W-1:0]    in_data,
  input  logic                 in_sof,
  output logic [16*ELEM_W-1:0] a_flat,
  output logic [16*ELEM_W-1:0] b_flat,
  output logic                 mat_valid,
  input  logic                 mat_ready,
  output logic [4:0]           elem_cnt
);

  localparam logic [1:0] LOAD_A = 2'd0;
  localparam logic [1:0] LOAD_B = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;

  logic [1:0]        state;
  logic [4:0]        cnt;
  logic [ELEM_W-1:0] a_mem [16];
  logic [ELEM_W-1:0] b_mem [16];
  logic              xfer;
  logic [3:0]        b_slot;

  assign in_ready  = (state != HOLD);
  assign mat_valid = (state == HOLD);
  assign elem_cnt  = cnt;
  assign xfer      = in_valid && in_ready;

  // In LOAD_B cnt runs 16..31, so its low nibble is the B element number n.
`ifdef MATLOAD_TRANSPOSE_B_EN
  // n-th element lands at B[n%4][n/4] -> flat index (n%4)*4 + n/4.
  assign b_slot = {cnt[1:0], cnt[3:2]};
`else
  assign b_slot = cnt[3:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD_A;
      cnt   <= '0;
      for (int unsigned i = 0; i < 16; i++) begin
        a_mem[i] <= '0;
        b_mem[i] <= '0;
      end
    end else begin
      case (state)
        LOAD_A, LOAD_B: begin
          if (xfer) begin
            if (in_sof) begin
              // Restart: this element is A[0][0], partial frame dropped.
              a_mem[0] <= in_data;
              cnt      <= 5'd1;
              state    <= LOAD_A;
            end else if (state == LOAD_A) begin
              a_mem[cnt[3:0]] <= in_data;
              cnt             <= cnt + 5'd1;
              if (cnt == 5'd15) state <= LOAD_B;
            end else begin
              b_mem[b_slot] <= in_data;
              if (cnt == 5'd31) begin
                cnt   <= '0;
                state <= HOLD;
              end else begin
                cnt <= cnt + 5'd1;
              end
            end
          end
        end
        HOLD: begin
          if (mat_ready) state <= LOAD_A;
        end
        default: state <= LOAD_A;
      endcase
    end
  end

  always_comb begin
    a_flat = '0;
    b_flat = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      a_flat[i*ELEM_W +: ELEM_W] = a_mem[i];
      b_flat[i*ELEM_W +: ELEM_W] = b_mem[i];
    end
  end

endmodule

// File: tb/tb_matrix_stream_loader.sv
// tb_matrix_stream_loader
//   Lockstep bench: each cycle drives inputs, advances a matrix-level model
//   (element number n -> A or B coordinates by arithmetic) and compares all
//   outputs against it, plus directed spot checks on selected elements.
module tb_matrix_stream_loader;

  localparam int W = 8;

  logic            clk = 1'b0;
  logic            rst, in_valid, in_ready, in_sof, mat_valid, mat_ready;
  logic [W-1:0]    in_data;
  logic [16*W-1:0] a_flat, b_flat;
  logic [4:0]      elem_cnt;

  int tests  = 0;
  int errors = 0;

  // Model: matrices, frame position, whether a full pair is held.
  logic [W-1:0] ma [4][4];
  logic [W-1:0] mb [4][4];
  int           n;
  bit           held;
  int           frames;

  matrix_stream_loader #(.ELEM_W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sof(in_sof), .a_flat(a_flat), .b_flat(b_flat),
    .mat_valid(mat_valid), .mat_ready(mat_ready), .elem_cnt(elem_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [16*W-1:0] got,
                       input logic [16*W-1:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [16*W-1:0] flat_a();
    logic [16*W-1:0] f = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) f[(r*4+c)*W +: W] = ma[r][c];
    return f;
  endfunction

  function automatic logic [16*W-1:0] flat_b();
    logic [16*W-1:0] f = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) f[(r*4+c)*W +: W] = mb[r][c];
    return f;
  endfunction

  task automatic model(input logic r, input logic v, input logic s,
                       input logic mr, input logic [W-1:0] d);
    int m;
    if (r) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          ma[i][j] = '0;
          mb[i][j] = '0;
        end
      n    = 0;
      held = 0;
      return;
    end
    if (held) begin
      if (mr) held = 0;
    end else if (v) begin
      if (s) begin
        ma[0][0] = d;
        n        = 1;
      end else begin
        if (n < 16) ma[n/4][n%4] = d;
        else begin
          m = n - 16;
`ifdef MATLOAD_TRANSPOSE_B_EN
          mb[m%4][m/4] = d;
`else
          mb[m/4][m%4] = d;
`endif
        end
        n++;
        if (n == 32) begin
          n    = 0;
          held = 1;
          frames++;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic v, input logic s,
                      input logic mr, input logic [W-1:0] d);
    rst = r; in_valid = v; in_sof = s; mat_ready = mr; in_data = d;
    @(posedge clk);
    model(r, v, s, mr, d);
    #1;
    check("in_ready",  {127'd0, in_ready},  {127'd0, !held});
    check("mat_valid", {127'd0, mat_valid}, {127'd0, held});
    check("elem_cnt",  {123'd0, elem_cnt},  n[4:0]);
    check("a_flat",    a_flat, flat_a());
    check("b_flat",    b_flat, flat_b());
  endtask

  initial begin
    logic [16*W-1:0] snap_a, snap_b;
    logic [W-1:0]    b10_exp, b01_exp;
    frames = 0;
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; mat_ready = 1'b0; in_data = '0;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("rst_a_zero", a_flat, '0);
    check("rst_cnt", {123'd0, elem_cnt}, 128'd0);

    // Stream 1..32 back to back, downstream not ready.
    for (int i = 1; i <= 32; i++) begin
      step(0, 1, 0, 0, W'(i));
      if (i == 31) check("mv_before_32", {127'd0, mat_valid}, 128'd0);
    end
    check("mv_after_32", {127'd0, mat_valid}, 128'd1);
    check("A00", {120'd0, a_flat[0 +: W]},          128'd1);
    check("A33", {120'd0, a_flat[15*W +: W]},       128'd16);
    check("B00", {120'd0, b_flat[0 +: W]},          128'd17);
    check("B33", {120'd0, b_flat[15*W +: W]},       128'd32);
`ifdef MATLOAD_TRANSPOSE_B_EN
    b10_exp = 8'd18; b01_exp = 8'd21;
`else
    b10_exp = 8'd21; b01_exp = 8'd18;
`endif
    check("B10", {120'd0, b_flat[4*W +: W]}, {120'd0, b10_exp});
    check("B01", {120'd0, b_flat[1*W +: W]}, {120'd0, b01_exp});

    // Hold for 10 cycles with upstream still pushing, then handshake.
    snap_a = a_flat; snap_b = b_flat;
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 8'hEE);
    check("hold_a_stable", a_flat, snap_a);
    check("hold_b_stable", b_flat, snap_b);
    step(0, 0, 0, 1, 0);
    check("post_hs_ready", {127'd0, in_ready},  128'd1);
    check("post_hs_mv",    {127'd0, mat_valid}, 128'd0);

    // 20 elements, sof restart with 0xAA, then 31 more.
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, W'(8'h40 + i));
    step(0, 1, 1, 0, 8'hAA);
    check("sof_cnt", {123'd0, elem_cnt}, 128'd1);
    for (int i = 0; i < 31; i++) begin
      if (i == 30) check("sof_mv_early", {127'd0, mat_valid}, 128'd0);
      step(0, 1, 0, 0, W'(8'h60 + i));
    end
    check("sof_mv", {127'd0, mat_valid}, 128'd1);
    check("sof_A00", {120'd0, a_flat[0 +: W]}, 128'hAA);
    step(0, 0, 1, 1, 0);

    // sof with no transfer is ignored, then reset mid-LOAD_B at count 23.
    step(0, 0, 1, 0, 8'h55);
    for (int i = 0; i < 23; i++) step(0, 1, 0, 0, W'(8'h80 + i));
    check("pre_rst_cnt", {123'd0, elem_cnt}, 128'd23);
    step(1, 1, 1, 1, 8'h11);
    check("rst_cnt23", {123'd0, elem_cnt}, 128'd0);
    check("rst_a", a_flat, '0);
    check("rst_b", b_flat, '0);
    check("rst_mv", {127'd0, mat_valid}, 128'd0);

    // Random traffic: 50% valid, rare sof, random downstream readiness.
    frames = 0;
    for (int i = 0; i < 1500; i++)
      step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 59) == 0),
           1'($urandom_range(0, 1)), W'($urandom));
    if (frames < 5) begin
      errors++;
      tests++;
      $display("FAIL rand_frames: got %0d expected at least 5", frames);
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
